// File: rtl/decode_issue_ctrl_pkg.sv
// Shared types for the decode/issue controller: register index, scoreboard vector,
// issue FSM states and the instruction op-type encoding.
// Optional feature macro used by this slice: WB_BYPASS_EN (see issue_scoreboard).
package decode_issue_ctrl_pkg;

  localparam int NREGS = 32;
  localparam logic [3:0] MAX_STALL = 4'd15;

  typedef logic [4:0]       reg_idx_t;
  typedef logic [NREGS-1:0] scoreboard_t;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STALL      = 2'd1,
    FENCE_WAIT = 2'd2
  } issue_state_e;

  // Encoding 3'd7 is unused; the controller treats it like R_TYPE.
  typedef enum logic [2:0] {
    R_TYPE   = 3'd0,
    I_TYPE   = 3'd1,
    S_TYPE   = 3'd2,
    B_TYPE   = 3'd3,
    U_TYPE   = 3'd4,
    J_TYPE   = 3'd5,
    SYS_TYPE = 3'd6
  } instruction_op_type;

  // One-hot mask for a register index.
  function automatic scoreboard_t onehot(input reg_idx_t idx);
    scoreboard_t m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/decode_issue_ctrl_scoreboard.sv
// issue_scoreboard: busy vector of in-flight register writes plus hazard detect for the held op.
// Ports: i_set_* marks a destination busy on issue, i_wb_* clears on writeback,
//        i_rs1/i_rs2/i_rd (+qualifiers) describe the held op, o_busy / o_hazard report state.
// WB_BYPASS_EN: when defined, a register retiring this cycle is not counted as a hazard.
module issue_scoreboard
  import decode_issue_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_set_vld,
  input  reg_idx_t    i_set_rd,
  input  logic        i_wb_valid,
  input  reg_idx_t    i_wb_rd,
  input  reg_idx_t    i_rs1,
  input  logic        i_use_rs1,
  input  reg_idx_t    i_rs2,
  input  logic        i_use_rs2,
  input  reg_idx_t    i_rd,
  input  logic        i_wr_rd,
  output scoreboard_t o_busy,
  output logic        o_hazard
);

  scoreboard_t r_busy;
  scoreboard_t w_set_mask;
  scoreboard_t w_clr_mask;
  scoreboard_t w_chk_busy;

  always_comb begin
    w_set_mask = (i_set_vld && i_set_rd != '0) ? onehot(i_set_rd) : '0;
    w_clr_mask = (i_wb_valid && i_wb_rd != '0) ? onehot(i_wb_rd) : '0;
  end

  // Clear first, then set: a new producer issuing in the retire cycle keeps the bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & ~scoreboard_t'(1);
    end
  end

`ifdef WB_BYPASS_EN
  assign w_chk_busy = r_busy & ~w_clr_mask;
`else
  assign w_chk_busy = r_busy;
`endif

  always_comb begin
    o_hazard = 1'b0;
    if (i_use_rs1 && i_rs1 != '0 && w_chk_busy[i_rs1]) o_hazard = 1'b1;
    if (i_use_rs2 && i_rs2 != '0 && w_chk_busy[i_rs2]) o_hazard = 1'b1;
    if (i_wr_rd   && i_rd  != '0 && w_chk_busy[i_rd])  o_hazard = 1'b1;
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: one-entry hold register between decode and execute, issuing when the
// scoreboard reports no RAW/WAW hazard; SYSTEM ops wait for all writes to retire; flush kills.
// Ports: i_id_* decoded op in (valid/ready), o_ex_* issue out (valid/ready), i_wb_* retire,
//        i_flush, o_busy_mask scoreboard view, o_stall_cnt saturating stall counter.
// Config macro: WB_BYPASS_EN (writeback bypass into the hazard check, in issue_scoreboard).
module decode_issue_ctrl
  import decode_issue_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_id_valid,
  output logic        o_id_ready,
  input  logic [4:0]  i_id_rs1,
  input  logic        i_id_use_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic        i_id_use_rs2,
  input  logic [4:0]  i_id_rd,
  input  logic        i_id_wr_rd,
  input  logic [2:0]  i_id_optype,
  output logic        o_ex_valid,
  input  logic        i_ex_ready,
  output logic [4:0]  o_ex_rd,
  input  logic        i_wb_valid,
  input  logic [4:0]  i_wb_rd,
  input  logic        i_flush,
  output logic [31:0] o_busy_mask,
  output logic [3:0]  o_stall_cnt
);

  issue_state_e r_state;
  logic [3:0]   r_stall_cnt;

  logic         r_held;
  reg_idx_t     r_rs1;
  reg_idx_t     r_rs2;
  reg_idx_t     r_rd;
  logic         r_use_rs1;
  logic         r_use_rs2;
  logic         r_wr_rd;
  logic [2:0]   r_optype;

  scoreboard_t  w_busy;
  logic         w_hazard_raw;
  logic         w_hazard;
  logic         w_is_sys;
  logic         w_fence_blk;
  logic         w_issue;
  logic         w_accept;

  issue_scoreboard u_sb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_set_vld  (w_issue && r_wr_rd),
    .i_set_rd   (r_rd),
    .i_wb_valid (i_wb_valid),
    .i_wb_rd    (i_wb_rd),
    .i_rs1      (r_rs1),
    .i_use_rs1  (r_use_rs1),
    .i_rs2      (r_rs2),
    .i_use_rs2  (r_use_rs2),
    .i_rd       (r_rd),
    .i_wr_rd    (r_wr_rd),
    .o_busy     (w_busy),
    .o_hazard   (w_hazard_raw)
  );

  // Unknown encodings fall through as non-SYSTEM, i.e. no fence.
  assign w_is_sys = (r_optype == SYS_TYPE);
  assign w_hazard = r_held && w_hazard_raw;
  // A SYSTEM op must not slip out in RUN while writes are still in flight.
  assign w_fence_blk = r_held && w_is_sys && (w_busy != '0);

  assign o_ex_valid = r_held && !w_hazard && (r_state != FENCE_WAIT) && !w_fence_blk && !i_flush;
  assign w_issue    = o_ex_valid && i_ex_ready;
  // Accept in the issue cycle for zero-bubble flow; a flush drops the incoming op.
  assign o_id_ready = (!r_held || w_issue) && !i_flush;
  assign w_accept   = i_id_valid && o_id_ready;

  assign o_ex_rd     = (r_held && r_wr_rd) ? r_rd : 5'd0;
  assign o_busy_mask = w_busy;
  assign o_stall_cnt = r_stall_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_held    <= 1'b0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_use_rs1 <= 1'b0;
      r_use_rs2 <= 1'b0;
      r_wr_rd   <= 1'b0;
      r_optype  <= R_TYPE;
    end else if (i_flush) begin
      r_held <= 1'b0;
    end else if (w_accept) begin
      r_held    <= 1'b1;
      r_rs1     <= i_id_rs1;
      r_rs2     <= i_id_rs2;
      r_rd      <= i_id_rd;
      r_use_rs1 <= i_id_use_rs1;
      r_use_rs2 <= i_id_use_rs2;
      r_wr_rd   <= i_id_wr_rd;
      r_optype  <= i_id_optype;
    end else if (w_issue) begin
      r_held <= 1'b0;
    end
  end

  // Issue FSM and stall counter; the counter tracks consecutive cycles spent hazard-stalled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= RUN;
      r_stall_cnt <= '0;
    end else if (i_flush) begin
      r_state     <= RUN;
      r_stall_cnt <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_hazard) begin
            r_state     <= STALL;
            r_stall_cnt <= (r_stall_cnt == MAX_STALL) ? r_stall_cnt : r_stall_cnt + 4'd1;
          end else if (w_fence_blk) begin
            r_state     <= FENCE_WAIT;
            r_stall_cnt <= '0;
          end else begin
            r_stall_cnt <= '0;
          end
        end
        STALL: begin
          if (w_hazard) begin
            r_stall_cnt <= (r_stall_cnt == MAX_STALL) ? r_stall_cnt : r_stall_cnt + 4'd1;
          end else begin
            r_state     <= RUN;
            r_stall_cnt <= '0;
          end
        end
        FENCE_WAIT: begin
          r_stall_cnt <= '0;
          if (w_busy == '0) r_state <= RUN;
        end
        default: begin
          r_state     <= RUN;
          r_stall_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
module tb_decode_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [4:0]  id_rs1;
  logic        id_use_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs2;
  logic [4:0]  id_rd;
  logic        id_wr_rd;
  logic [2:0]  id_optype;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [31:0] busy_mask;
  logic [3:0]  stall_cnt;

  int n_cmp;
  int n_bad;

  decode_issue_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_id_valid   (id_valid),
    .o_id_ready   (id_ready),
    .i_id_rs1     (id_rs1),
    .i_id_use_rs1 (id_use_rs1),
    .i_id_rs2     (id_rs2),
    .i_id_use_rs2 (id_use_rs2),
    .i_id_rd      (id_rd),
    .i_id_wr_rd   (id_wr_rd),
    .i_id_optype  (id_optype),
    .o_ex_valid   (ex_valid),
    .i_ex_ready   (ex_ready),
    .o_ex_rd      (ex_rd),
    .i_wb_valid   (wb_valid),
    .i_wb_rd      (wb_rd),
    .i_flush      (flush),
    .o_busy_mask  (busy_mask),
    .o_stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge; inputs are then changed and outputs
  // checked 1ns later, well away from either edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_op(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic wr,
                          input logic [2:0] opt);
    id_valid   = 1'b1;
    id_rs1     = rs1;
    id_use_rs1 = u1;
    id_rs2     = rs2;
    id_use_rs2 = u2;
    id_rd      = rd;
    id_wr_rd   = wr;
    id_optype  = opt;
  endtask

  task automatic no_op();
    id_valid   = 1'b0;
    id_use_rs1 = 1'b0;
    id_use_rs2 = 1'b0;
    id_wr_rd   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ex_ready = 1'b1;
    wb_valid = 1'b0;
    wb_rd = 5'd0;
    flush = 1'b0;
    drive_op(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 3'd0);
    step();
    step();
    rst = 1'b0;
    settle();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ex_valid: got %0b want 0", ex_valid); end
    n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL reset_id_ready: got %0b want 1", id_ready); end
    n_cmp++; if (busy_mask !== 32'h0) begin n_bad++; $display("FAIL reset_busy: got %h want 0", busy_mask); end
    n_cmp++; if (stall_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    n_cmp++; if (ex_rd !== 5'd0) begin n_bad++; $display("FAIL reset_ex_rd: got %0d want 0", ex_rd); end
    // The op on id_valid is accepted now and must issue next cycle (rd=3 becomes busy).
    step();
    no_op();
    settle();
    n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL reset_first_issue: got %0b want 1", ex_valid); end
    n_cmp++; if (ex_rd !== 5'd3) begin n_bad++; $display("FAIL reset_first_rd: got %0d want 3", ex_rd); end
    step();
    wb_valid = 1'b1; wb_rd = 5'd3;
    settle();
    n_cmp++; if (busy_mask !== 32'h8) begin n_bad++; $display("FAIL reset_busy3: got %h want 8", busy_mask); end
    step();
    wb_valid = 1'b0;
    settle();
    n_cmp++; if (busy_mask !== 32'h0) begin n_bad++; $display("FAIL reset_wb_clear: got %h want 0", busy_mask); end
  endtask

  task automatic test_raw_stall();
    drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 3'd0);
    step();
    drive_op(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
    settle();
    n_cmp++; if (ex_valid !== 1'b1 || ex_rd !== 5'd5) begin n_bad++; $display("FAIL raw_producer_issue: got v=%0b rd=%0d want v=1 rd=5", ex_valid, ex_rd); end
    n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL raw_zero_bubble_ready: got %0b want 1", id_ready); end
    step();
    no_op();
    settle();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL raw_stall_first: got %0b want 0", ex_valid); end
    n_cmp++; if (busy_mask !== 32'h20) begin n_bad++; $display("FAIL raw_busy5: got %h want 20", busy_mask); end
    n_cmp++; if (id_ready !== 1'b0) begin n_bad++; $display("FAIL raw_id_ready_full: got %0b want 0", id_ready); end
    for (int i = 1; i <= 3; i++) begin
      step();
      if (i == 3) begin wb_valid = 1'b1; wb_rd = 5'd5; end
      settle();
      n_cmp++; if (stall_cnt !== 4'(i)) begin n_bad++; $display("FAIL raw_stall_cnt_%0d: got %0d want %0d", i, stall_cnt, i); end
    end
`ifdef WB_BYPASS_EN
    n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL raw_bypass_issue: got %0b want 1", ex_valid); end
    step();
    wb_valid = 1'b0;
    settle();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL raw_bypass_done: got %0b want 0", ex_valid); end
`else
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL raw_nobypass_wb_cycle: got %0b want 0", ex_valid); end
    step();
    wb_valid = 1'b0;
    settle();
    n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL raw_nobypass_issue: got %0b want 1", ex_valid); end
`endif
    step();
    settle();
    n_cmp++; if (ex_valid !== 1'b0 || stall_cnt !== 4'd0 || busy_mask !== 32'h0) begin
      n_bad++; $display("FAIL raw_drained: got v=%0b cnt=%0d busy=%h want 0/0/0", ex_valid, stall_cnt, busy_mask);
    end
  endtask

  task automatic test_x0();
    drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 3'd1);
    step();
    drive_op(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
    settle();
    n_cmp++; if (ex_valid !== 1'b1 || ex_rd !== 5'd0) begin n_bad++; $display("FAIL x0_writer: got v=%0b rd=%0d want 1/0", ex_valid, ex_rd); end
    step();
    no_op();
    settle();
    n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL x0_reader_b2b: got %0b want 1", ex_valid); end
    n_cmp++; if (busy_mask !== 32'h0) begin n_bad++; $display("FAIL x0_busy: got %h want 0", busy_mask); end
    step();
    settle();
    n_cmp++; if (ex_valid !== 1'b0 || busy_mask !== 32'h0) begin n_bad++; $display("FAIL x0_idle: got v=%0b busy=%h want 0/0", ex_valid, busy_mask); end
  endtask

  task automatic test_fence();
    drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 3'd0);
    step();
    drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd6);
    settle();
    n_cmp++; if (ex_valid !== 1'b1 || ex_rd !== 5'd3) begin n_bad++; $display("FAIL fence_producer: got v=%0b rd=%0d want 1/3", ex_valid, ex_rd); end
    step();
    no_op();
    settle();
    n_cmp++; if (ex_valid !== 1'b0 || busy_mask !== 32'h8) begin n_bad++; $display("FAIL fence_block_run: got v=%0b busy=%h want 0/8", ex_valid, busy_mask); end
    step();
    settle();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL fence_wait1: got %0b want 0", ex_valid); end
    step();
    wb_valid = 1'b1; wb_rd = 5'd3;
    settle();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL fence_wait_wb: got %0b want 0", ex_valid); end
    step();
    wb_valid = 1'b0;
    settle();
    n_cmp++; if (ex_valid !== 1'b0 || busy_mask !== 32'h0) begin n_bad++; $display("FAIL fence_still_wait: got v=%0b busy=%h want 0/0", ex_valid, busy_mask); end
    step();
    settle();
    n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL fence_sys_issue: got %0b want 1", ex_valid); end
    step();
    settle();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL fence_done: got %0b want 0", ex_valid); end
  endtask

  task automatic test_flush();
    drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 3'd0);
    step();
    drive_op(5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 3'd0);
    step();
    no_op();
    step();
    step();
    settle();
    n_cmp++; if (stall_cnt !== 4'd2 || ex_valid !== 1'b0) begin n_bad++; $display("FAIL flush_pre_stall: got cnt=%0d v=%0b want 2/0", stall_cnt, ex_valid); end
    flush = 1'b1;
    drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 3'd0);
    settle();
    n_cmp++; if (id_ready !== 1'b0 || ex_valid !== 1'b0) begin n_bad++; $display("FAIL flush_cycle: got rdy=%0b v=%0b want 0/0", id_ready, ex_valid); end
    step();
    flush = 1'b0;
    no_op();
    settle();
    n_cmp++; if (ex_valid !== 1'b0 || stall_cnt !== 4'd0) begin n_bad++; $display("FAIL flush_after: got v=%0b cnt=%0d want 0/0", ex_valid, stall_cnt); end
    n_cmp++; if (busy_mask !== 32'h80) begin n_bad++; $display("FAIL flush_busy7: got %h want 80", busy_mask); end
    n_cmp++; if (id_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready: got %0b want 1", id_ready); end
    step();
    settle();
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL flush_dropped_op: got %0b want 0", ex_valid); end
    wb_valid = 1'b1; wb_rd = 5'd7;
    step();
    wb_valid = 1'b0;
    settle();
    n_cmp++; if (busy_mask !== 32'h0) begin n_bad++; $display("FAIL flush_wb7: got %h want 0", busy_mask); end
  endtask

  task automatic test_saturate_and_setwins();
    drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd0);
    step();
    drive_op(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0);
    step();
    no_op();
    for (int i = 1; i <= 20; i++) begin
      step();
      settle();
      n_cmp++; if (stall_cnt !== ((i > 15) ? 4'd15 : 4'(i))) begin
        n_bad++; $display("FAIL sat_cnt_%0d: got %0d want %0d", i, stall_cnt, (i > 15) ? 15 : i);
      end
    end
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL sat_no_issue: got %0b want 0", ex_valid); end
    wb_valid = 1'b1; wb_rd = 5'd9;
    step();
    wb_valid = 1'b0;
    step();
    step();
    settle();
    n_cmp++; if (ex_valid !== 1'b0 || stall_cnt !== 4'd0 || busy_mask !== 32'h0) begin
      n_bad++; $display("FAIL sat_drained: got v=%0b cnt=%0d busy=%h want 0/0/0", ex_valid, stall_cnt, busy_mask);
    end
    // Issue rd=9 in the same cycle a writeback retires r9: the new producer must stay busy.
    drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 3'd0);
    step();
    no_op();
    wb_valid = 1'b1; wb_rd = 5'd9;
    settle();
    n_cmp++; if (ex_valid !== 1'b1 || ex_rd !== 5'd9) begin n_bad++; $display("FAIL setwins_issue: got v=%0b rd=%0d want 1/9", ex_valid, ex_rd); end
    step();
    wb_valid = 1'b0;
    // Unknown op type with writes outstanding: must not fence.
    drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd7);
    settle();
    n_cmp++; if (busy_mask !== 32'h200) begin n_bad++; $display("FAIL setwins_busy9: got %h want 200", busy_mask); end
    step();
    no_op();
    settle();
    n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL unknown_op_no_fence: got %0b want 1", ex_valid); end
    wb_valid = 1'b1; wb_rd = 5'd9;
    step();
    wb_valid = 1'b0;
    settle();
    n_cmp++; if (busy_mask !== 32'h0 || ex_valid !== 1'b0) begin n_bad++; $display("FAIL final_idle: got busy=%h v=%0b want 0/0", busy_mask, ex_valid); end
  endtask

  task automatic test_backpressure();
    drive_op(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 3'd0);
    ex_ready = 1'b0;
    step();
    no_op();
    for (int i = 0; i < 3; i++) begin
      settle();
      n_cmp++; if (ex_valid !== 1'b1 || ex_rd !== 5'd12 || id_ready !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold_%0d: got v=%0b rd=%0d rdy=%0b want 1/12/0", i, ex_valid, ex_rd, id_ready);
      end
      step();
    end
    ex_ready = 1'b1;
    step();
    settle();
    n_cmp++; if (busy_mask !== 32'h1000 || ex_valid !== 1'b0) begin n_bad++; $display("FAIL bp_issued: got busy=%h v=%0b want 1000/0", busy_mask, ex_valid); end
    wb_valid = 1'b1; wb_rd = 5'd12;
    step();
    wb_valid = 1'b0;
    settle();
    n_cmp++; if (busy_mask !== 32'h0) begin n_bad++; $display("FAIL bp_wb: got %h want 0", busy_mask); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    id_valid = 1'b0; id_rs1 = '0; id_use_rs1 = 1'b0; id_rs2 = '0; id_use_rs2 = 1'b0;
    id_rd = '0; id_wr_rd = 1'b0; id_optype = '0;
    ex_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0; rst = 1'b1;
    test_reset();
    test_raw_stall();
    test_x0();
    test_fence();
    test_flush();
    test_saturate_and_setwins();
    test_backpressure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
